// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative radix-2 shift-add multiplier for RV64M MUL/MULH/MULHSU/MULHU.
// One product bit is formed per cycle and only one operation is in flight at a time.
// Requests and responses both use a valid/ready handshake.
// Optional feature macro: SEQ_MUL_EARLY_OUT_EN. When it is defined, the multiplier finishes
// early once every multiplier bit still to be consumed is zero. Results are unchanged.
module seq_multiplier #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_COUNT = CW'(XLEN - 1);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t          r_state;
  logic [1:0]      r_op;
  logic            r_neg;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN:0]   r_acc;
  logic [CW-1:0]   r_count;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [XLEN-1:0] r_result;
`ifdef SEQ_MUL_EARLY_OUT_EN
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] w_rem_next;
  logic [CW-1:0]   w_shamt;
`endif

  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic [XLEN:0]   w_sum;
  logic [2*XLEN-1:0] w_raw;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_final;
  logic            w_last;
  logic [XLEN-1:0] w_result;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;

  // Reduce the incoming operands to unsigned magnitudes and work out the product sign.
  // The most-negative value negates to itself, which is already its correct unsigned magnitude.
  always_comb begin
    w_a_signed = (op == OP_MULH) || (op == OP_MULHSU);
    w_b_signed = (op == OP_MULH);
    w_a_neg    = w_a_signed & a[XLEN-1];
    w_b_neg    = w_b_signed & b[XLEN-1];
    w_a_mag    = w_a_neg ? -a : a;
    w_b_mag    = w_b_neg ? -b : b;
  end

  // Compute one shift-add step and, in case this step is the last, the final signed product half.
  // The sum keeps one extra bit so that a full-width multiplicand can never overflow it.
  always_comb begin
    w_sum = r_acc + (r_mplier[0] ? {1'b0, r_mcand} : {(XLEN+1){1'b0}});
    w_raw = {w_sum, r_mplier[XLEN-1:1]};
`ifdef SEQ_MUL_EARLY_OUT_EN
    w_rem_next = r_rem >> 1;
    w_shamt    = LAST_COUNT - r_count;
    w_prod     = w_raw >> w_shamt;
    w_last     = (r_count == LAST_COUNT) || (w_rem_next == '0);
`else
    w_prod     = w_raw;
    w_last     = (r_count == LAST_COUNT);
`endif
    w_final  = r_neg ? -w_prod : w_prod;
    w_result = (r_op == OP_MUL) ? w_final[XLEN-1:0] : w_final[2*XLEN-1:XLEN];
  end

  // Control FSM and datapath registers. A flush takes priority over every other transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= OP_MUL;
      r_neg       <= 1'b0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
`ifdef SEQ_MUL_EARLY_OUT_EN
      r_rem       <= '0;
`endif
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_op       <= op;
            r_neg      <= w_a_neg ^ w_b_neg;
            r_mcand    <= w_a_mag;
            r_mplier   <= w_b_mag;
            r_acc      <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_CALC;
`ifdef SEQ_MUL_EARLY_OUT_EN
            r_rem      <= w_b_mag;
`endif
          end
        end
        S_CALC: begin
          r_acc    <= {1'b0, w_sum[XLEN:1]};
          r_mplier <= {w_sum[0], r_mplier[XLEN-1:1]};
          r_count  <= r_count + CW'(1);
`ifdef SEQ_MUL_EARLY_OUT_EN
          r_rem    <= w_rem_next;
`endif
          if (w_last) begin
            r_result    <= w_result;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
